// File: rtl/sayeh_memory_responder_pkg.sv
// Shared encodings and defaults for the SAYEH memory responder.
// Also meant to be shared with the testbench and later cache work.
package sayeh_memory_responder_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int BUS_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

  // Latched op still requested and the opposite strobe not raised.
  function automatic logic req_held(
    input mem_op_e op,
    input logic    rd,
    input logic    wr
  );
    return (op == OP_READ) ? (rd && !wr) : (wr && !rd);
  endfunction

endpackage

// File: rtl/sayeh_mem_array.sv
// Single-port word storage for the SAYEH memory responder.
// Synchronous write; synchronous read into a resettable data register.
module sayeh_mem_array
  import sayeh_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/sayeh_memory_responder.sv
// SAYEH bus memory responder: wait-state FSM, MemDataReady, tri-state read drive.
// Define SAYEH_MEM_BUSERR_EN to add the BusError output and upper-address checking.
module sayeh_memory_responder
  import sayeh_memory_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  ExternalReset,
  input  logic [15:0]           Addressbus,
  inout  wire  [DATA_WIDTH-1:0] Databus,
  input  logic                  ReadMem,
  input  logic                  WriteMem,
`ifdef SAYEH_MEM_BUSERR_EN
  output logic                  BusError,
`endif
  output logic                  MemDataReady
);

`ifdef SAYEH_MEM_BUSERR_EN
  localparam int LW = BUS_ADDR_WIDTH;
`else
  localparam int LW = ADDR_WIDTH;
`endif

  ms_state_e             state, nxt;
  mem_op_e               op_q, op_nxt;
  logic [LW-1:0]         addr_q, addr_nxt;
  logic [3:0]            cnt_q, cnt_nxt;
  logic                  commit;
  logic                  addr_err;
  logic                  we, re, drv;
  logic [DATA_WIDTH-1:0] rdata;

`ifdef SAYEH_MEM_BUSERR_EN
  assign addr_err = |addr_q[LW-1:ADDR_WIDTH];
`else
  // Upper address bits alias onto the implemented range.
  logic unused_hi;
  assign unused_hi = ^Addressbus[15:ADDR_WIDTH];
  assign addr_err  = 1'b0;
`endif

  always_comb begin
    nxt      = state;
    op_nxt   = op_q;
    addr_nxt = addr_q;
    cnt_nxt  = cnt_q;
    commit   = 1'b0;
    unique case (state)
      MS_IDLE: begin
        if (ReadMem ^ WriteMem) begin
          nxt      = MS_BUSY;
          op_nxt   = WriteMem ? OP_WRITE : OP_READ;
          addr_nxt = Addressbus[LW-1:0];
          cnt_nxt  = 4'(WAIT_STATES);
        end
      end
      MS_BUSY: begin
        if (!req_held(op_q, ReadMem, WriteMem)) begin
          nxt = MS_IDLE;
        end else if (cnt_q == 4'd0) begin
          nxt    = MS_DONE;
          commit = 1'b1;
        end else begin
          cnt_nxt = 4'(cnt_q - 4'd1);
        end
      end
      MS_DONE: begin
        if (!((op_q == OP_READ) ? ReadMem : WriteMem)) nxt = MS_IDLE;
      end
      default: nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge ExternalReset) begin
    if (ExternalReset) begin
      state        <= MS_IDLE;
      op_q         <= OP_READ;
      addr_q       <= '0;
      cnt_q        <= '0;
      MemDataReady <= 1'b0;
    end else begin
      state        <= nxt;
      op_q         <= op_nxt;
      addr_q       <= addr_nxt;
      cnt_q        <= cnt_nxt;
      MemDataReady <= (nxt == MS_DONE);
    end
  end

`ifdef SAYEH_MEM_BUSERR_EN
  always_ff @(posedge clk or posedge ExternalReset) begin
    if (ExternalReset) BusError <= 1'b0;
    else BusError <= (state == MS_IDLE && ReadMem && WriteMem) ||
                     (nxt == MS_DONE && addr_err);
  end
`endif

  assign we = commit && (op_q == OP_WRITE) && !addr_err;
  assign re = commit && (op_q == OP_READ);

  sayeh_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (ExternalReset),
    .we   (we),
    .re   (re),
    .addr (addr_q[ADDR_WIDTH-1:0]),
    .wdata(Databus),
    .rdata(rdata)
  );

  // Enable comes straight from registered state so the bus never glitches.
  assign drv     = (state == MS_DONE) && (op_q == OP_READ);
  assign Databus = drv ? (addr_err ? '0 : rdata) : 'z;

endmodule

// File: tb/tb_sayeh_memory_responder.sv
// Scoreboard bench for sayeh_memory_responder (WAIT_STATES=2 and 0 instances).
// Bus is pulled high so an undriven Databus reads 16'hFFFF.
module tb_sayeh_memory_responder;
  import sayeh_memory_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] ab [2];
  logic [15:0] td [2];
  logic [1:0]  rd, wr, tdrv, rdy;
`ifdef SAYEH_MEM_BUSERR_EN
  logic [1:0]  berr;
`endif
  tri1  [15:0] bus0, bus1;

  assign bus0 = tdrv[0] ? td[0] : 'z;
  assign bus1 = tdrv[1] ? td[1] : 'z;

  sayeh_memory_responder #(.WAIT_STATES(2)) u_ws2 (
    .clk          (clk),
    .ExternalReset(rst),
    .Addressbus   (ab[0]),
    .Databus      (bus0),
    .ReadMem      (rd[0]),
    .WriteMem     (wr[0]),
`ifdef SAYEH_MEM_BUSERR_EN
    .BusError     (berr[0]),
`endif
    .MemDataReady (rdy[0])
  );

  sayeh_memory_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk          (clk),
    .ExternalReset(rst),
    .Addressbus   (ab[1]),
    .Databus      (bus1),
    .ReadMem      (rd[1]),
    .WriteMem     (wr[1]),
`ifdef SAYEH_MEM_BUSERR_EN
    .BusError     (berr[1]),
`endif
    .MemDataReady (rdy[1])
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] mdl [2][1024];
  logic [15:0] expq [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] busv(input int u);
    return (u == 0) ? bus0 : bus1;
  endfunction

  function automatic int ws(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  task automatic access(input int u, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input bit hop, input bit err);
    int n;
    bit seen;
    logic [15:0] e;
    @(negedge clk);
    ab[u] = a;
    if (w) begin
      wr[u] = 1'b1; tdrv[u] = 1'b1; td[u] = d;
    end else begin
      rd[u] = 1'b1;
      expq.push_back(err ? 16'h0000 : mdl[u][a[9:0]]);
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (hop && n == 1) ab[u] = a + 16'd1;
      seen = rdy[u];
    end
    chk("latency", n, ws(u) + 2);
`ifdef SAYEH_MEM_BUSERR_EN
    chk("buserr_done", {31'd0, berr[u]}, {31'd0, err});
`endif
    if (!w) begin
      e = expq.pop_front();
      chk("rdata", busv(u), e);
    end else if (!err) begin
      mdl[u][a[9:0]] = d;
    end
    @(negedge clk);
    rd[u] = 1'b0; wr[u] = 1'b0; tdrv[u] = 1'b0;
    @(posedge clk); #1;
    chk("rdy_drop", {31'd0, rdy[u]}, 32'd0);
    chk("bus_z", busv(u), 16'hFFFF);
  endtask

  initial begin
    bit hit;
    rst = 1'b1; rd = '0; wr = '0; tdrv = '0;
    ab[0] = '0; ab[1] = '0; td[0] = '0; td[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {30'd0, rdy}, 32'd0);
    chk("rst_bus0", bus0, 16'hFFFF);
    chk("rst_bus1", bus1, 16'hFFFF);
    @(negedge clk); rst = 1'b0;

    // Write then read with two wait states.
    access(0, 1'b1, 16'h0005, 16'h1234, 1'b0, 1'b0);
    access(0, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0);

    // Reset in the middle of a write must not commit it.
    access(0, 1'b1, 16'h0010, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    ab[0] = 16'h0010; wr[0] = 1'b1; tdrv[0] = 1'b1; td[0] = 16'hBEEF;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b1; tdrv[0] = 1'b0;
    #1;
    chk("rstmid_rdy", {31'd0, rdy[0]}, 32'd0);
    chk("rstmid_bus", bus0, 16'hFFFF);
    @(negedge clk); rst = 1'b0; wr[0] = 1'b0;
    access(0, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);

    // Abort a write after one busy cycle.
    access(0, 1'b1, 16'h0020, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    ab[0] = 16'h0020; wr[0] = 1'b1; tdrv[0] = 1'b1; td[0] = 16'hDEAD;
    @(posedge clk); @(posedge clk);
    @(negedge clk); wr[0] = 1'b0; tdrv[0] = 1'b0;
    hit = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      hit |= rdy[0];
    end
    chk("abort_rdy", {31'd0, hit}, 32'd0);
    access(0, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);

    // Address change while busy must not redirect the access.
    access(0, 1'b1, 16'h0006, 16'h5678, 1'b0, 1'b0);
    access(0, 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b0);

    // Zero wait states, back-to-back reads at both ends of the array.
    access(1, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 1'b0);
    access(1, 1'b1, 16'h03FF, 16'h5AA5, 1'b0, 1'b0);
    access(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    access(1, 1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b0);

`ifdef SAYEH_MEM_BUSERR_EN
    access(0, 1'b0, 16'h0400, 16'h0000, 1'b0, 1'b1);
    access(0, 1'b1, 16'h0407, 16'h7777, 1'b0, 1'b1);
    access(0, 1'b1, 16'h0007, 16'h0707, 1'b0, 1'b0);
    access(0, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0);
    @(negedge clk); rd[0] = 1'b1; wr[0] = 1'b1;
    @(posedge clk); #1;
    chk("both_berr", {31'd0, berr[0]}, 32'd1);
    chk("both_rdy", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk); rd[0] = 1'b0; wr[0] = 1'b0;
    @(posedge clk); #1;
    chk("both_berr_end", {31'd0, berr[0]}, 32'd0);
    chk("both_rdy_end", {31'd0, rdy[0]}, 32'd0);
`else
    // Upper address bits alias onto the low 1K words.
    access(0, 1'b1, 16'h0407, 16'h7777, 1'b0, 1'b0);
    access(0, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0);
    @(negedge clk); rd[0] = 1'b1; wr[0] = 1'b1;
    hit = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      hit |= rdy[0];
    end
    chk("both_ignored", {31'd0, hit}, 32'd0);
    @(negedge clk); rd[0] = 1'b0; wr[0] = 1'b0;
    access(0, 1'b0, 16'h0407, 16'h0000, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
